// File: rtl/rob_commit_if.sv
// Bundle between the reorder buffer and its neighbours: decoder allocation,
// rs/lsb result broadcasts, operand queries and the retire-side outputs.
interface rob_commit_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 rob_full;
  logic [ROB_WIDTH-1:0] tail_id;

  logic                 dec_ready;
  logic [1:0]           dec_kind;
  logic [4:0]           dec_rd;
  logic [31:0]          dec_pred_addr;

  logic                 rs_ready;
  logic [ROB_WIDTH-1:0] rs_rob_id;
  logic [31:0]          rs_value;
  logic                 lsb_ready;
  logic [ROB_WIDTH-1:0] lsb_rob_id;
  logic [31:0]          lsb_value;

  logic [ROB_WIDTH-1:0] qry_j_id;
  logic [ROB_WIDTH-1:0] qry_k_id;
  logic                 qry_j_ready;
  logic                 qry_k_ready;
  logic [31:0]          qry_j_value;
  logic [31:0]          qry_k_value;

  logic                 commit_valid;
  logic [4:0]           commit_rd;
  logic [31:0]          commit_value;
  logic [ROB_WIDTH-1:0] commit_rob_id;
  logic                 store_commit;
  logic [ROB_WIDTH-1:0] store_rob_id;
  logic                 clear;
  logic [31:0]          clear_pc;
  logic                 halt;

  modport slave (
    input  dec_ready, dec_kind, dec_rd, dec_pred_addr,
    input  rs_ready, rs_rob_id, rs_value, lsb_ready, lsb_rob_id, lsb_value,
    input  qry_j_id, qry_k_id,
    output rob_full, tail_id, qry_j_ready, qry_k_ready, qry_j_value, qry_k_value,
    output commit_valid, commit_rd, commit_value, commit_rob_id,
    output store_commit, store_rob_id, clear, clear_pc, halt
  );

  modport master (
    output dec_ready, dec_kind, dec_rd, dec_pred_addr,
    output rs_ready, rs_rob_id, rs_value, lsb_ready, lsb_rob_id, lsb_value,
    output qry_j_id, qry_k_id,
    input  rob_full, tail_id, qry_j_ready, qry_k_ready, qry_j_value, qry_k_value,
    input  commit_valid, commit_rd, commit_value, commit_rob_id,
    input  store_commit, store_rob_id, clear, clear_pc, halt
  );
endinterface

// File: rtl/rob_commit.sv
// In-order reorder buffer: allocates at issue, captures rs/lsb results,
// answers operand queries and retires one entry per cycle with registered pulses.
module rob_commit #(
  parameter int ROB_WIDTH = 4,
  parameter int ROB_SIZE  = 16
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         rdy_in,
  rob_commit_if.slave  bus
);
  localparam logic [1:0] KIND_REG    = 2'd0;
  localparam logic [1:0] KIND_BRANCH = 2'd1;
  localparam logic [1:0] KIND_STORE  = 2'd2;
  localparam logic [1:0] KIND_HALT   = 2'd3;

  logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_WIDTH:0]   count_q, count_d;

  logic                 commit_valid_q, commit_valid_d;
  logic [4:0]           commit_rd_q, commit_rd_d;
  logic [31:0]          commit_value_q, commit_value_d;
  logic [ROB_WIDTH-1:0] commit_id_q, commit_id_d;
  logic                 store_commit_q, store_commit_d;
  logic [ROB_WIDTH-1:0] store_id_q, store_id_d;
  logic                 clear_q, clear_d;
  logic [31:0]          clear_pc_q, clear_pc_d;
  logic                 halt_q, halt_d;

  logic        ent_busy  [ROB_SIZE];
  logic        ent_ready [ROB_SIZE];
  logic [1:0]  ent_kind  [ROB_SIZE];
  logic [4:0]  ent_rd    [ROB_SIZE];
  logic [31:0] ent_pred  [ROB_SIZE];
  logic [31:0] ent_value [ROB_SIZE];

  logic full, alloc_en, retire_en, mispredict;

  assign full       = (count_q == (ROB_WIDTH+1)'(ROB_SIZE));
  assign alloc_en   = bus.dec_ready && !full && !clear_q && !halt_q;
  assign retire_en  = (count_q != '0) && ent_busy[head_q] && ent_ready[head_q]
                      && !clear_q && !halt_q;
  assign mispredict = retire_en && (ent_kind[head_q] == KIND_BRANCH)
                      && (ent_value[head_q] != ent_pred[head_q]);

  genvar gi;
  generate
    for (gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
      logic        busy_q, ready_q;
      logic [1:0]  kind_q;
      logic [4:0]  rd_q;
      logic [31:0] pred_q, value_q;
      logic        rs_hit, lsb_hit, alloc_hit, retire_hit;

      assign rs_hit     = bus.rs_ready  && (bus.rs_rob_id  == ROB_WIDTH'(gi)) && busy_q && !clear_q;
      assign lsb_hit    = bus.lsb_ready && (bus.lsb_rob_id == ROB_WIDTH'(gi)) && busy_q && !clear_q;
      assign alloc_hit  = alloc_en  && (tail_q == ROB_WIDTH'(gi));
      assign retire_hit = retire_en && (head_q == ROB_WIDTH'(gi));

      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          kind_q  <= KIND_REG;
          rd_q    <= '0;
          pred_q  <= '0;
          value_q <= '0;
        end else if (rdy_in) begin
          // lsb has priority when both units report the same tag
          if (lsb_hit) begin
            ready_q <= 1'b1;
            value_q <= bus.lsb_value;
          end else if (rs_hit) begin
            ready_q <= 1'b1;
            value_q <= bus.rs_value;
          end
          if (alloc_hit) begin
            busy_q  <= 1'b1;
            ready_q <= (bus.dec_kind == KIND_HALT);
            kind_q  <= bus.dec_kind;
            rd_q    <= bus.dec_rd;
            pred_q  <= bus.dec_pred_addr;
          end else if (retire_hit) begin
            busy_q  <= 1'b0;
          end
          if (mispredict) busy_q <= 1'b0;
        end
      end

      assign ent_busy[gi]  = busy_q;
      assign ent_ready[gi] = ready_q;
      assign ent_kind[gi]  = kind_q;
      assign ent_rd[gi]    = rd_q;
      assign ent_pred[gi]  = pred_q;
      assign ent_value[gi] = value_q;
    end
  endgenerate

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q + {{ROB_WIDTH{1'b0}}, alloc_en} - {{ROB_WIDTH{1'b0}}, retire_en};
    commit_valid_d = 1'b0;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;
    commit_id_d    = commit_id_q;
    store_commit_d = 1'b0;
    store_id_d     = store_id_q;
    clear_d        = 1'b0;
    clear_pc_d     = clear_pc_q;
    halt_d         = halt_q;
    if (alloc_en) tail_d = tail_q + 1'b1;
    if (retire_en) begin
      head_d = head_q + 1'b1;
      case (ent_kind[head_q])
        KIND_REG: begin
          commit_valid_d = 1'b1;
          commit_rd_d    = ent_rd[head_q];
          commit_value_d = ent_value[head_q];
          commit_id_d    = head_q;
        end
        KIND_STORE: begin
          store_commit_d = 1'b1;
          store_id_d     = head_q;
        end
        KIND_BRANCH: begin
          // a wrong prediction discards every younger entry, including this cycle's allocation
          if (mispredict) begin
            clear_d    = 1'b1;
            clear_pc_d = ent_value[head_q];
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
          end
        end
        default: halt_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_id_q    <= '0;
      store_commit_q <= 1'b0;
      store_id_q     <= '0;
      clear_q        <= 1'b0;
      clear_pc_q     <= '0;
      halt_q         <= 1'b0;
    end else if (rdy_in) begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      commit_id_q    <= commit_id_d;
      store_commit_q <= store_commit_d;
      store_id_q     <= store_id_d;
      clear_q        <= clear_d;
      clear_pc_q     <= clear_pc_d;
      halt_q         <= halt_d;
    end
  end

  assign bus.rob_full      = full;
  assign bus.tail_id       = tail_q;
  assign bus.qry_j_ready   = ent_busy[bus.qry_j_id] && ent_ready[bus.qry_j_id];
  assign bus.qry_k_ready   = ent_busy[bus.qry_k_id] && ent_ready[bus.qry_k_id];
  assign bus.qry_j_value   = ent_value[bus.qry_j_id];
  assign bus.qry_k_value   = ent_value[bus.qry_k_id];
  assign bus.commit_valid  = commit_valid_q;
  assign bus.commit_rd     = commit_rd_q;
  assign bus.commit_value  = commit_value_q;
  assign bus.commit_rob_id = commit_id_q;
  assign bus.store_commit  = store_commit_q;
  assign bus.store_rob_id  = store_id_q;
  assign bus.clear         = clear_q;
  assign bus.clear_pc      = clear_pc_q;
  assign bus.halt          = halt_q;
endmodule
